// File: rtl/event_priority_encoder_if.sv
// Bundle of the request, grant and status signals of event_priority_encoder.
// Grant handshake: a transfer happens on a rising edge where valid_out=1 and
// ready_in=1; while valid_out=1 and ready_in=0, idx_out holds its value and
// valid_out stays high.
interface event_priority_encoder_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req_in;
  logic          ready_in;
  logic          clr_ovf;
  logic [IW-1:0] idx_out;
  logic          valid_out;
  logic [N-1:0]  pending;
  logic          ovf;

  modport master (
    output req_in, ready_in, clr_ovf,
    input  idx_out, valid_out, pending, ovf
  );

  modport slave (
    input  req_in, ready_in, clr_ovf,
    output idx_out, valid_out, pending, ovf
  );
endinterface

// File: rtl/event_priority_encoder.sv
// Captures request pulses on N lines and hands out one pending index per
// valid/ready transfer, in lowest-first, highest-first or round-robin order.
module event_priority_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  event_priority_encoder_if.slave bus
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  pending_q;
  logic [IW-1:0] idx_q;
  logic          valid_q;
  logic          ovf_q;
  logic [IW-1:0] rr_q;

  logic [IW-1:0] sel;
  logic          found;
  logic [IW:0]   probe;
  logic          load;
  logic [N-1:0]  sel_mask;
  logic [N-1:0]  overlap;
  logic [IW-1:0] rr_next;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    probe = '0;
    if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && pending_q[i]) begin
          sel   = IW'(i);
          found = 1'b1;
        end
      end
    end else if (MODE == 2) begin
      // Walk upward from rr, wrapping at N (not 2^IW) so odd sizes stay in range.
      for (int k = 0; k < N; k++) begin
        probe = {1'b0, rr_q} + (IW+1)'(k);
        if (probe >= (IW+1)'(N)) begin
          probe = probe - (IW+1)'(N);
        end
        if (!found && pending_q[probe[IW-1:0]]) begin
          sel   = probe[IW-1:0];
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && pending_q[i]) begin
          sel   = IW'(i);
          found = 1'b1;
        end
      end
    end
  end

  assign load     = (pending_q != '0) && (!valid_q || bus.ready_in);
  assign sel_mask = load ? (N'(1) << sel) : '0;
  // The bit leaving for the output register is free to take a new event.
  assign overlap  = bus.req_in & pending_q & ~sel_mask;
  assign rr_next  = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      rr_q      <= '0;
    end else begin
      pending_q <= (pending_q & ~sel_mask) | bus.req_in;
      if (load) begin
        idx_q   <= sel;
        valid_q <= 1'b1;
        rr_q    <= rr_next;
      end else if (valid_q && bus.ready_in) begin
        valid_q <= 1'b0;
      end
      if (overlap != '0) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.idx_out   = idx_q;
  assign bus.valid_out = valid_q;
  assign bus.pending   = pending_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_event_priority_encoder.sv
// Directed bench for event_priority_encoder: four instances (N/MODE variants),
// expected grant orders queued by the stimulus and checked by per-instance monitors.
module tb_event_priority_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  event_priority_encoder_if #(.N(8)) a_if ();
  event_priority_encoder_if #(.N(8)) b_if ();
  event_priority_encoder_if #(.N(4)) c_if ();
  event_priority_encoder_if #(.N(5)) d_if ();

  event_priority_encoder #(.N(8), .MODE(0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  event_priority_encoder #(.N(8), .MODE(1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  event_priority_encoder #(.N(4), .MODE(2)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
  event_priority_encoder #(.N(5), .MODE(2)) u_d (.clk(clk), .rst(rst), .bus(d_if.slave));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];
  logic [7:0] exp_d[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && a_if.valid_out && a_if.ready_in) begin
      if (exp_a.size() == 0) check("a_unexpected_grant", 64'(a_if.idx_out), 64'hff);
      else check("a_grant", 64'(a_if.idx_out), 64'(exp_a.pop_front()));
    end
    if (!rst && b_if.valid_out && b_if.ready_in) begin
      if (exp_b.size() == 0) check("b_unexpected_grant", 64'(b_if.idx_out), 64'hff);
      else check("b_grant", 64'(b_if.idx_out), 64'(exp_b.pop_front()));
    end
    if (!rst && c_if.valid_out && c_if.ready_in) begin
      if (exp_c.size() == 0) check("c_unexpected_grant", 64'(c_if.idx_out), 64'hff);
      else check("c_grant", 64'(c_if.idx_out), 64'(exp_c.pop_front()));
    end
    if (!rst && d_if.valid_out && d_if.ready_in) begin
      if (exp_d.size() == 0) check("d_unexpected_grant", 64'(d_if.idx_out), 64'hff);
      else check("d_grant", 64'(d_if.idx_out), 64'(exp_d.pop_front()));
      check("d_idx_in_range", 64'(d_if.idx_out < 3'd5), 64'd1);
    end
  end

  initial begin
    a_if.req_in = '0; a_if.ready_in = 1'b0; a_if.clr_ovf = 1'b0;
    b_if.req_in = '0; b_if.ready_in = 1'b0; b_if.clr_ovf = 1'b0;
    c_if.req_in = '0; c_if.ready_in = 1'b0; c_if.clr_ovf = 1'b0;
    d_if.req_in = '0; d_if.ready_in = 1'b0; d_if.clr_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Test 1: build state (grant held, pending bit, ovf), then async reset mid-cycle.
    a_if.req_in = 8'h02;
    tick();
    tick();
    tick();
    a_if.req_in = 8'h00;
    tick();
    check("t1_pre_valid", 64'(a_if.valid_out), 64'd1);
    check("t1_pre_idx", 64'(a_if.idx_out), 64'd1);
    check("t1_pre_pending", 64'(a_if.pending), 64'h02);
    check("t1_pre_ovf", 64'(a_if.ovf), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_rst_valid", 64'(a_if.valid_out), 64'd0);
    check("t1_rst_idx", 64'(a_if.idx_out), 64'd0);
    check("t1_rst_pending", 64'(a_if.pending), 64'h00);
    check("t1_rst_ovf", 64'(a_if.ovf), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_idle_valid", 64'(a_if.valid_out), 64'd0);
      check("t1_idle_pending", 64'(a_if.pending), 64'h00);
    end

    // Test 2: single pulse on d3 -> index 3 after two edges.
    exp_a.push_back(8'd3);
    a_if.ready_in = 1'b1;
    a_if.req_in = 8'h08;
    tick();
    a_if.req_in = 8'h00;
    check("t2_pending", 64'(a_if.pending), 64'h08);
    check("t2_valid_early", 64'(a_if.valid_out), 64'd0);
    tick();
    check("t2_valid", 64'(a_if.valid_out), 64'd1);
    check("t2_idx", 64'(a_if.idx_out), 64'd3);
    check("t2_pending_moved", 64'(a_if.pending), 64'h00);
    tick();
    check("t2_valid_drop", 64'(a_if.valid_out), 64'd0);

    // Test 3: 8'hA5 with a 5-cycle stall, lowest-first and highest-first.
    exp_a.push_back(8'd0); exp_a.push_back(8'd2); exp_a.push_back(8'd5); exp_a.push_back(8'd7);
    exp_b.push_back(8'd7); exp_b.push_back(8'd5); exp_b.push_back(8'd2); exp_b.push_back(8'd0);
    a_if.ready_in = 1'b0;
    b_if.ready_in = 1'b0;
    a_if.req_in = 8'hA5;
    b_if.req_in = 8'hA5;
    tick();
    a_if.req_in = 8'h00;
    b_if.req_in = 8'h00;
    check("t3_a_pending", 64'(a_if.pending), 64'hA5);
    check("t3_b_pending", 64'(b_if.pending), 64'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_a_stall_valid", 64'(a_if.valid_out), 64'd1);
      check("t3_a_stall_idx", 64'(a_if.idx_out), 64'd0);
      check("t3_b_stall_idx", 64'(b_if.idx_out), 64'd7);
    end
    check("t3_a_stall_pending", 64'(a_if.pending), 64'hA4);
    check("t3_b_stall_pending", 64'(b_if.pending), 64'h25);
    a_if.ready_in = 1'b1;
    b_if.ready_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t3_a_done_valid", 64'(a_if.valid_out), 64'd0);
    check("t3_b_done_valid", 64'(b_if.valid_out), 64'd0);
    check("t3_a_done_pending", 64'(a_if.pending), 64'h00);
    check("t3_a_no_ovf", 64'(a_if.ovf), 64'd0);

    // Test 4: round-robin N=4, lines held for 8 samples -> 11 back-to-back grants.
    for (int k = 0; k < 11; k++) exp_c.push_back(8'(k % 4));
    c_if.ready_in = 1'b1;
    c_if.req_in = 4'hF;
    tick();
    for (int i = 0; i < 11; i++) begin
      tick();
      check("t4_no_bubble", 64'(c_if.valid_out), 64'd1);
      if (i == 6) c_if.req_in = 4'h0;
    end
    tick();
    check("t4_done_valid", 64'(c_if.valid_out), 64'd0);
    check("t4_done_pending", 64'(c_if.pending), 64'h0);
    check("t4_ovf", 64'(c_if.ovf), 64'd1);

    // Test 5: overflow while stalled, clear, then re-requests around the load/transfer of 4.
    exp_a.push_back(8'd1); exp_a.push_back(8'd4); exp_a.push_back(8'd4); exp_a.push_back(8'd4);
    a_if.ready_in = 1'b0;
    a_if.req_in = 8'h02;
    tick();
    a_if.req_in = 8'h00;
    tick();
    check("t5_held_idx", 64'(a_if.idx_out), 64'd1);
    a_if.req_in = 8'h10;
    tick();
    check("t5_first_no_ovf", 64'(a_if.ovf), 64'd0);
    tick();
    check("t5_ovf_set", 64'(a_if.ovf), 64'd1);
    check("t5_pending_single", 64'(a_if.pending), 64'h10);
    a_if.req_in = 8'h00;
    a_if.clr_ovf = 1'b1;
    tick();
    a_if.clr_ovf = 1'b0;
    check("t5_ovf_clear", 64'(a_if.ovf), 64'd0);
    a_if.ready_in = 1'b1;
    a_if.req_in = 8'h10;
    tick();
    check("t5_load_req_no_ovf", 64'(a_if.ovf), 64'd0);
    check("t5_load_req_pending", 64'(a_if.pending), 64'h10);
    check("t5_load_idx", 64'(a_if.idx_out), 64'd4);
    a_if.req_in = 8'h00;
    tick();
    check("t5_reload_idx", 64'(a_if.idx_out), 64'd4);
    check("t5_reload_pending", 64'(a_if.pending), 64'h00);
    a_if.req_in = 8'h10;
    tick();
    a_if.req_in = 8'h00;
    check("t5_xfer_req_no_ovf", 64'(a_if.ovf), 64'd0);
    check("t5_xfer_req_pending", 64'(a_if.pending), 64'h10);
    check("t5_xfer_valid", 64'(a_if.valid_out), 64'd0);
    tick();
    check("t5_second_grant_valid", 64'(a_if.valid_out), 64'd1);
    check("t5_second_grant_idx", 64'(a_if.idx_out), 64'd4);
    tick();
    check("t5_done_valid", 64'(a_if.valid_out), 64'd0);

    // Test 6: N=5 round-robin, wrap from 4 back to 0.
    exp_d.push_back(8'd0); exp_d.push_back(8'd4);
    exp_d.push_back(8'd1); exp_d.push_back(8'd4);
    exp_d.push_back(8'd0); exp_d.push_back(8'd1);
    d_if.ready_in = 1'b1;
    d_if.req_in = 5'h11;
    tick();
    d_if.req_in = 5'h00;
    tick();
    check("t6_first_idx", 64'(d_if.idx_out), 64'd0);
    tick();
    check("t6_second_idx", 64'(d_if.idx_out), 64'd4);
    tick();
    check("t6_idle_valid", 64'(d_if.valid_out), 64'd0);
    d_if.req_in = 5'h12;
    tick();
    d_if.req_in = 5'h00;
    for (int i = 0; i < 3; i++) tick();
    d_if.req_in = 5'h03;
    tick();
    d_if.req_in = 5'h00;
    for (int i = 0; i < 4; i++) tick();
    check("t6_done_valid", 64'(d_if.valid_out), 64'd0);

    tick();
    check("a_queue_empty", 64'(exp_a.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    check("c_queue_empty", 64'(exp_c.size()), 64'd0);
    check("d_queue_empty", 64'(exp_d.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
